// File: rtl/motor_drive_decoder.sv
// Wheel-pair H-bridge driver: decodes DIR into per-wheel duty/polarity, slews duty,
// zeroes a wheel before reversing it, times 90-degree pivots and generates both PWMs.

module motor_drive_wheel #(
  parameter int RAMP_STEP = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] i_tgt_duty,
  input  logic        i_tgt_pol,
  input  logic        i_stop,
  input  logic        i_active,
  input  logic        i_tick,
  input  logic        i_wrap,
  input  logic [11:0] i_pwm_cnt,
  output logic        o_pwm,
  output logic        o_fwd,
  output logic        o_rev,
  output logic        o_mis,
  output logic        o_rdy
);
  localparam logic [11:0] STEP = 12'(RAMP_STEP);

  logic        r_pol, r_en;
  logic [11:0] r_duty, r_lat;
  logic [11:0] w_eff, w_next;
  logic        w_idle;

  assign o_mis  = (i_tgt_pol != r_pol);
  assign o_rdy  = !o_mis && r_en;
  assign w_eff  = o_mis ? 12'd0 : i_tgt_duty;
  // Reverse only once the pin-level duty is also drained, so no current flows at the swap.
  assign w_idle = (r_duty == 12'd0) && (r_lat == 12'd0);

  always_comb begin
    w_next = r_duty;
    if (w_eff > r_duty)
      w_next = ((w_eff - r_duty) > STEP) ? r_duty + STEP : w_eff;
    else if (w_eff < r_duty)
      w_next = ((r_duty - w_eff) > STEP) ? r_duty - STEP : w_eff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pol  <= 1'b0;
      r_en   <= 1'b0;
      r_duty <= 12'd0;
      r_lat  <= 12'd0;
    end else if (i_stop) begin
      r_duty <= 12'd0;
      r_lat  <= 12'd0;
      r_en   <= 1'b0;
    end else begin
      if (i_tick && i_active && r_en) r_duty <= w_next;
      if (i_wrap) r_lat <= r_duty;
      if (!i_active)  r_en <= 1'b0;
      else if (!o_mis) r_en <= 1'b1;
      else if (w_idle) begin
        // One cycle with both pins low, then the new polarity.
        if (r_en) r_en <= 1'b0;
        else begin
          r_pol <= i_tgt_pol;
          r_en  <= 1'b1;
        end
      end
    end
  end

  assign o_pwm = (i_pwm_cnt < r_lat);
  assign o_fwd = r_en & ~r_pol;
  assign o_rev = r_en & r_pol;
endmodule

module motor_drive_decoder #(
  parameter int PWM_PERIOD = 2500,
  parameter int DUTY_FULL  = 2500,
  parameter int DUTY_VEER  = 1500,
  parameter int DUTY_HARD  = 600,
  parameter int DUTY_PIVOT = 1800,
  parameter int RAMP_DIV   = 50000,
  parameter int RAMP_STEP  = 125,
  parameter int PIVOT_TIME = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] DIR,
  output logic       PWM_L,
  output logic       PWM_R,
  output logic       L_FWD,
  output logic       L_REV,
  output logic       R_FWD,
  output logic       R_REV,
  output logic       BUSY
);
  localparam int RW      = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int FULL_C  = (DUTY_FULL  > PWM_PERIOD) ? PWM_PERIOD : DUTY_FULL;
  localparam int VEER_C  = (DUTY_VEER  > PWM_PERIOD) ? PWM_PERIOD : DUTY_VEER;
  localparam int HARD_C  = (DUTY_HARD  > PWM_PERIOD) ? PWM_PERIOD : DUTY_HARD;
  localparam int PIVOT_C = (DUTY_PIVOT > PWM_PERIOD) ? PWM_PERIOD : DUTY_PIVOT;
  localparam logic [11:0] D_FULL  = 12'(FULL_C);
  localparam logic [11:0] D_VEER  = 12'(VEER_C);
  localparam logic [11:0] D_HARD  = 12'(HARD_C);
  localparam logic [11:0] D_PIVOT = 12'(PIVOT_C);

  typedef enum logic [1:0] {S_STOP, S_RUN, S_FLIP, S_PIVOT} state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_dir_q, r_piv_cmd, w_cmd;
  logic            r_busy;
  logic [24:0]     r_ptmr;
  logic [11:0]     r_pwm_cnt;
  logic [RW-1:0]   r_rdiv;
  logic            w_stop, w_pivot, w_wrap, w_tick, w_active, w_enter_piv;
  logic [11:0]     w_in_duty, w_out_duty;
  logic            w_in_pol;
  logic [1:0][11:0] w_tgt_duty;
  logic [1:0]      w_tgt_pol, w_mis, w_rdy, w_pwm, w_fwd, w_rev;

  assign w_stop   = (r_dir_q[3:2] == 2'b11);
  // While the pivot minimum time runs, non-stop codes are ignored.
  assign w_cmd    = (r_state == S_PIVOT && r_busy && !w_stop) ? r_piv_cmd : r_dir_q;
  assign w_pivot  = (w_cmd[3:2] == 2'b01 || w_cmd[3:2] == 2'b10) && (w_cmd[1:0] == 2'b11);
  assign w_wrap   = (r_pwm_cnt == 12'(PWM_PERIOD - 1));
  assign w_tick   = (r_rdiv == RW'(RAMP_DIV - 1));
  assign w_active = (r_state != S_STOP) && !w_stop;

  always_comb begin
    w_tgt_duty = '0;
    w_tgt_pol  = '0;
    w_in_duty  = D_FULL;
    w_out_duty = D_FULL;
    w_in_pol   = 1'b0;
    case (w_cmd[1:0])
      2'b01:   w_in_duty = D_VEER;
      2'b10:   w_in_duty = D_HARD;
      2'b11: begin
        w_in_duty  = D_PIVOT;
        w_out_duty = D_PIVOT;
        w_in_pol   = 1'b1;
      end
      default: ;
    endcase
    case (w_cmd[3:2])
      2'b00:   w_tgt_duty = {D_FULL, D_FULL};
      2'b01: begin
        w_tgt_duty = {w_out_duty, w_in_duty};
        w_tgt_pol  = {1'b0, w_in_pol};
      end
      2'b10: begin
        w_tgt_duty = {w_in_duty, w_out_duty};
        w_tgt_pol  = {w_in_pol, 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) w_state_nxt = S_STOP;
    else begin
      unique case (r_state)
        S_STOP, S_RUN: w_state_nxt = (|w_mis) ? S_FLIP : (w_pivot ? S_PIVOT : S_RUN);
        S_FLIP:  if (&w_rdy) w_state_nxt = w_pivot ? S_PIVOT : S_RUN;
        S_PIVOT: if (!r_busy) w_state_nxt = (|w_mis) ? S_FLIP : (w_pivot ? S_PIVOT : S_RUN);
      endcase
    end
  end

  assign w_enter_piv = (r_state != S_PIVOT) && (w_state_nxt == S_PIVOT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_STOP;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dir_q   <= 4'd0;
      r_piv_cmd <= 4'd0;
      r_busy    <= 1'b0;
      r_ptmr    <= 25'd0;
      r_pwm_cnt <= 12'd0;
      r_rdiv    <= '0;
    end else begin
      r_dir_q   <= DIR;
      r_pwm_cnt <= w_wrap ? 12'd0 : r_pwm_cnt + 12'd1;
      r_rdiv    <= w_tick ? '0 : r_rdiv + 1'b1;
      if (w_stop) begin
        r_busy <= 1'b0;
        r_ptmr <= 25'd0;
      end else if (w_enter_piv) begin
        r_busy    <= 1'b1;
        r_ptmr    <= 25'(PIVOT_TIME);
        r_piv_cmd <= r_dir_q;
      end else if (r_busy) begin
        r_ptmr <= r_ptmr - 25'd1;
        if (r_ptmr == 25'd1) r_busy <= 1'b0;
      end
    end
  end

  for (genvar w = 0; w < 2; w++) begin : g_wheel
    motor_drive_wheel #(.RAMP_STEP(RAMP_STEP)) u_wheel (
      .clk        (clk),
      .rst        (rst),
      .i_tgt_duty (w_tgt_duty[w]),
      .i_tgt_pol  (w_tgt_pol[w]),
      .i_stop     (w_stop),
      .i_active   (w_active),
      .i_tick     (w_tick),
      .i_wrap     (w_wrap),
      .i_pwm_cnt  (r_pwm_cnt),
      .o_pwm      (w_pwm[w]),
      .o_fwd      (w_fwd[w]),
      .o_rev      (w_rev[w]),
      .o_mis      (w_mis[w]),
      .o_rdy      (w_rdy[w])
    );
  end

  assign PWM_L = w_pwm[0];
  assign PWM_R = w_pwm[1];
  assign L_FWD = w_fwd[0];
  assign L_REV = w_rev[0];
  assign R_FWD = w_fwd[1];
  assign R_REV = w_rev[1];
  assign BUSY  = r_busy;
endmodule

// File: tb/tb_motor_drive_decoder.sv
// Directed + random bench for motor_drive_decoder with a tag/expected scoreboard
// and a continuous polarity-safety monitor.

module tb_motor_drive_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] DIR = 4'b1100;
  logic       PWM_L, PWM_R, L_FWD, L_REV, R_FWD, R_REV, BUSY;
  logic [11:0] l_duty, r_duty;

  int n_cmp = 0;
  int n_bad = 0;
  int l_chg = 0;
  logic [1:0] pl = 2'b00;
  logic [1:0] pr = 2'b00;

  typedef struct {
    string tag;
    int    exp;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  motor_drive_decoder #(
    .PWM_PERIOD(10), .DUTY_FULL(10), .DUTY_VEER(6), .DUTY_HARD(3), .DUTY_PIVOT(8),
    .RAMP_DIV(2), .RAMP_STEP(5), .PIVOT_TIME(40)
  ) dut (
    .clk(clk), .rst(rst), .DIR(DIR),
    .PWM_L(PWM_L), .PWM_R(PWM_R),
    .L_FWD(L_FWD), .L_REV(L_REV), .R_FWD(R_FWD), .R_REV(R_REV),
    .BUSY(BUSY)
  );

  assign l_duty = dut.g_wheel[0].u_wheel.r_duty;
  assign r_duty = dut.g_wheel[1].u_wheel.r_duty;

  function automatic int outs();
    return int'({PWM_L, PWM_R, L_FWD, L_REV, R_FWD, R_REV, BUSY});
  endfunction

  function automatic int pins();
    return int'({L_FWD, L_REV, R_FWD, R_REV});
  endfunction

  task automatic push(input string tag, input int exp);
    sb_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic check(input int obs);
    sb_t it;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $error("FAIL sb_underflow: observed %0d with no expected entry", obs);
      return;
    end
    it = sb_q.pop_front();
    assert (obs === it.exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", it.tag, obs, it.exp);
    end
  endtask

  task automatic count_pwm(input int n, output int cl, output int cr);
    cl = 0;
    cr = 0;
    repeat (n) begin
      @(negedge clk);
      cl += int'(PWM_L);
      cr += int'(PWM_R);
    end
  endtask

  task automatic ramp_watch(output int first_nz, output int last);
    first_nz = -1;
    repeat (20) begin
      @(negedge clk);
      if (first_nz < 0 && l_duty != 12'd0) first_nz = int'(l_duty);
    end
    last = int'(l_duty);
  endtask

  task automatic wait_busy(input int lim, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (BUSY) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Pins never both high; a pin only rises from coast, with zero duty and PWM low.
  always begin
    @(negedge clk);
    n_cmp++;
    assert (!(L_FWD && L_REV) && !(R_FWD && R_REV)) else begin
      n_bad++;
      $error("FAIL both_high: L=%b%b R=%b%b expected neither pair high", L_FWD, L_REV, R_FWD, R_REV);
    end
    if ({L_FWD, L_REV} != pl) l_chg++;
    if (({L_FWD, L_REV} & ~pl) != 2'b00) begin
      n_cmp++;
      assert (pl == 2'b00 && l_duty == 12'd0 && !PWM_L) else begin
        n_bad++;
        $error("FAIL l_pol_rise: prev=%b duty=%0d pwm=%b expected prev=00 duty=0 pwm=0", pl, l_duty, PWM_L);
      end
    end
    if (({R_FWD, R_REV} & ~pr) != 2'b00) begin
      n_cmp++;
      assert (pr == 2'b00 && r_duty == 12'd0 && !PWM_R) else begin
        n_bad++;
        $error("FAIL r_pol_rise: prev=%b duty=%0d pwm=%b expected prev=00 duty=0 pwm=0", pr, r_duty, PWM_R);
      end
    end
    pl = {L_FWD, L_REV};
    pr = {R_FWD, R_REV};
  end

  initial begin
    int   a, b, k;
    logic ok;

    // Reset state
    repeat (3) @(negedge clk);
    push("reset_outs", 0);
    push("reset_duty", 0);
    check(outs());
    check(int'(l_duty));

    // Power-up proceed: ramp 0 -> 5 -> 10, forward pins, full PWM
    DIR = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    push("pwr_ramp_first", 5);
    push("pwr_ramp_last", 10);
    push("pwr_pins", 4'b1010);
    ramp_watch(a, b);
    check(a);
    check(b);
    check(pins());
    repeat (20) @(negedge clk);
    push("full_pwm_l", 10);
    push("full_pwm_r", 10);
    count_pwm(10, a, b);
    check(a);
    check(b);

    // Left veer: left 6/10, right 10/10, no polarity activity
    k = l_chg;
    DIR = 4'b0101;
    push("veer_pwm_l", 6);
    push("veer_pwm_r", 10);
    push("veer_no_flip", 0);
    repeat (30) @(negedge clk);
    count_pwm(10, a, b);
    check(a);
    check(b);
    check(l_chg - k);

    // Left 90-degree pivot from full, with an ignored proceed pulse while busy
    DIR = 4'b0000;
    repeat (30) @(negedge clk);
    DIR = 4'b0111;
    push("pivot_busy_seen", 1);
    push("pivot_pins", 4'b0110);
    push("pivot_busy_len", 40);
    push("pivot_pwm_l", 8);
    push("pivot_pwm_r", 8);
    push("pivot_hold_pins", 4'b0110);
    push("pivot_busy_off", 0);
    wait_busy(200, ok);
    check(int'(ok));
    check(pins());
    k = 0;
    while (BUSY && k < 100) begin
      k++;
      if (k == 10) DIR = 4'b0000;
      if (k == 13) DIR = 4'b0111;
      @(negedge clk);
    end
    check(k);
    repeat (5) @(negedge clk);
    count_pwm(10, a, b);
    check(a);
    check(b);
    check(pins());
    check(int'(BUSY));

    // Stop, then stop again mid-pivot
    DIR = 4'b1100;
    push("stop_outs", 0);
    repeat (3) @(negedge clk);
    check(outs());
    DIR = 4'b0111;
    push("pivot2_busy", 1);
    push("pivot2_drive", 1);
    push("stop_mid_pivot", 0);
    wait_busy(20, ok);
    check(int'(ok));
    count_pwm(20, a, b);
    check(int'(a > 0 && b > 0));
    DIR = 4'b1100;
    repeat (2) @(negedge clk);
    check(outs());

    // Asynchronous reset mid-ramp, then ramp restarts from zero
    DIR = 4'b0000;
    push("rst_found_duty5", 1);
    push("rst_async_outs", 0);
    push("rst_async_duty", 0);
    push("rst_ramp_first", 5);
    push("rst_ramp_last", 10);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (l_duty == 12'd5) begin
        ok = 1'b1;
        break;
      end
    end
    check(int'(ok));
    #2 rst = 1'b1;
    #1;
    check(outs());
    check(int'(l_duty));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ramp_watch(a, b);
    check(a);
    check(b);

    // Random command stream; the monitor guards polarity safety throughout
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) DIR = 4'($urandom_range(0, 15));
    end
    DIR = 4'b1100;
    push("final_stop", 0);
    repeat (3) @(negedge clk);
    check(outs());

    n_cmp++;
    assert (sb_q.size() == 0) else begin
      n_bad++;
      $error("FAIL sb_leftover: observed %0d pending expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/motor_drive_decoder.md
# motor_drive_decoder

Consumes the 4-bit `DIR` command from the line-following direction controller and drives both wheel H-bridges. It decodes the command into per-wheel target duty and polarity, slews each wheel's duty toward its target, and enforces zero-duty before any polarity reversal. It holds a timed pivot for 90-degree codes and generates the two PWM outputs. It sits between the direction controller and the motor driver pins.

## Interface
- `PWM_PERIOD`, 2500: PWM period in clk cycles (20 kHz at 50 MHz); 12-bit counter.
- `DUTY_FULL`, 2500: proceed duty, in counts.
- `DUTY_VEER`, 1500: inner-wheel duty for veer.
- `DUTY_HARD`, 600: inner-wheel duty for hard turn.
- `DUTY_PIVOT`, 1800: both-wheel duty during a 90-degree pivot.
- `RAMP_DIV`, 50000: clk cycles between ramp steps.
- `RAMP_STEP`, 125: maximum duty change per ramp step.
- `PIVOT_TIME`, 25000000: minimum pivot duration in clk cycles; 25-bit counter.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `DIR` in 4: [3:2] 00 proceed, 01 left, 10 right, 11 stop. [1:0] 00 full, 01 veer, 10 hard, 11 90-degree.
- `PWM_L`, `PWM_R` out 1: wheel enable PWM.
- `L_FWD`, `L_REV`, `R_FWD`, `R_REV` out 1: H-bridge polarity. Both low means coast; never both high.
- `BUSY` out 1: high while a pivot's minimum time is running.

## Operation
- `DIR` is registered once on entry (`dir_q`). All decoding uses `dir_q`.
- Decode of target (left duty/pol, right duty/pol):
  - 00_xx: FULL fwd / FULL fwd.
  - 01_01: VEER fwd / FULL fwd.
  - 01_10: HARD fwd / FULL fwd.
  - 01_11: PIVOT rev / PIVOT fwd.
  - 10_xx: mirror of 01_xx.
  - 01_00 and 10_00: treated as proceed.
  - 11_xx: stop.
- FSM states are RUN, FLIP, PIVOT, STOP. Reset state is STOP.
  - STOP: duty 0 on both wheels, all polarity pins low. Any non-11 code moves to RUN, or to FLIP if polarity must change.
  - RUN: each wheel's actual duty moves toward its target by at most RAMP_STEP per ramp tick. Overshoot is clamped to the target. A new code needing a polarity change on either wheel moves to FLIP.
  - FLIP: the affected wheel's target is forced to 0 and the wheel ramps down. When its actual duty equals 0, its polarity pins are changed (both low for one cycle, then the new pin high). A pivot code then goes to PIVOT; anything else goes to RUN.
  - PIVOT: the pivot timer loads PIVOT_TIME and `BUSY`=1. Non-stop `DIR` changes are ignored until the timer reaches 0. Then `BUSY`=0. If `dir_q` is still a 90 code, the block stays in PIVOT. Otherwise it re-decodes (FLIP or RUN).
- Stop (11_xx) overrides every state, including FLIP and PIVOT mid-count. Actual duty is set to 0 immediately (no ramp), pivot timer and `BUSY` clear, and the FSM goes to STOP.
- The ramp tick counter is free-running over 0..RAMP_DIV-1. A tick occurs at wrap.
- PWM counter runs 0..PWM_PERIOD-1. `PWM_x` = (counter < latched_duty_x). Latched duty updates only at counter wrap, except stop, which zeroes the latched duty at once.
- Duty arithmetic is 12-bit unsigned, saturating at 0 and at PWM_PERIOD.

## Timing
- Reset (async) value: `PWM_L`=`PWM_R`=0, all polarity pins 0, `BUSY`=0. All counters, actual duties and latched duties are 0. State is STOP.
- `DIR` to decode latency: 1 cycle (`dir_q`). `DIR`=11_xx to `PWM_x` low: 2 cycles after the edge on which `DIR` changes.
- Duty change reaches the pin at the next PWM wrap after the ramp tick.
- Polarity change is never issued while actual duty for that wheel is nonzero. There is ≥1 cycle of both-low between FWD and REV.
- `BUSY` rises the cycle PIVOT is entered and falls the cycle the timer reaches 0.
- Simultaneous ramp tick and new code: the tick applies toward the new target.
- Reset asserted mid-pivot or mid-flip takes effect immediately. All outputs are low within the same cycle, asynchronously.

## Test plan
Sim parameters: PERIOD=10, FULL=10, VEER=6, HARD=3, PIVOT=8, RAMP_DIV=2, RAMP_STEP=5, PIVOT_TIME=40.
- Reset released, `DIR`=00_00 → `L_FWD`/`R_FWD` high. Duty ramps 0→5→10 over two ticks. `PWM_L`/`PWM_R` are then constantly high.
- From full, `DIR`=01_01 → left duty drops to 6 (`PWM_L` high 6 of 10 cycles). Right stays at 10. No polarity change.
- From full, `DIR`=01_11 → left ramps to 0. `L_FWD` goes low, then one cycle later `L_REV` goes high. Both wheels are at duty 8. `BUSY` is high for 40 cycles. A `DIR`=00_00 pulse during that window is ignored.
- During the pivot at cycle 20, `DIR`=11_00 → `PWM_L`/`PWM_R` low within 2 cycles. All polarity pins go low and `BUSY` clears.
- Assert `rst` asynchronously mid-ramp (duty 5) → all outputs 0 immediately. After release with `DIR`=00_00, the ramp restarts from 0.
- Random `DIR` stream over 10k cycles → assert `x_FWD`&`x_REV` is never high, and polarity changes only when that wheel's actual duty is 0.
